key_seq_tx: RTL and testbench
=============================

# key_seq_tx

Serial key-sequence transmitter that drives the single-bit `keyinput` port of a logic-locked controller FSM. It holds a loaded unlock key, shifts it out LSB-first one bit per accepted beat under a valid/ready handshake, and counts completed sequences. After `MAX_USES` completed sequences it locks out permanently until reset. It sits between the key-provisioning logic and the locked controller's key port.

## Interface
- `KEY_W`, 8: key length in bits; legal range is 2 to 64.
- `MAX_USES`, 4: number of completed sequences before lockout; legal range is 1 to 255.
- `clk` input 1: clock. All block state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `load` input 1: capture `key_in`; accepted only in IDLE.
- `key_in` input KEY_W: key value to load.
- `start` input 1: begin a sequence; accepted only in IDLE.
- `abort` input 1: cancel the sequence in progress.
- `ready` input 1: the consumer accepts the current bit.
- `key_bit` output 1: current key bit. It is 0 whenever `key_valid` is 0.
- `key_valid` output 1: `key_bit` is valid.
- `busy` output 1: high in SEND.
- `done` output 1: one-cycle pulse after the final beat is accepted.
- `lockout` output 1: sticky; high in LOCK.
- `uses` output clog2(MAX_USES+1): count of completed sequences.

## Operation
- All outputs are registered.
- Reset values: every output is 0, the key register is 0, `loaded` is 0, the bit index is 0, and the state is IDLE.
- **IDLE**
  - If `load` is high, the key register takes `key_in` and `loaded` is set.
  - If `start` is high and `load` is low and `loaded` is 1, go to SEND with index 0, `key_valid` 1 and `key_bit` = key[0].
  - If `load` and `start` are high in the same cycle, the load is taken and the start is ignored.
  - A `start` while `loaded` is 0 is ignored.
- **SEND**
  - A beat is transferred on each rising edge where `key_valid` and `ready` are both 1.
  - After each transfer the index increments and `key_bit` shows key[index].
  - `key_bit` is stable while `ready` is low.
  - When the last beat is accepted, `uses` increments, `done` pulses for one cycle, and `key_valid` drops.
  - The next state is LOCK if the new `uses` equals `MAX_USES`; otherwise it is IDLE.
  - `load` and `start` are ignored.
- **abort in SEND**
  - The state returns to IDLE on the next edge with `key_valid` 0, `uses` unchanged and no `done`.
  - `abort` has priority over a beat accepted in the same cycle.
  - `abort` is ignored outside SEND.
- **LOCK**
  - `lockout` is 1 and all other inputs are ignored.
  - `key_valid` stays 0 and `uses` holds at `MAX_USES`.
  - Only `rst` exits LOCK.
- `uses` never wraps, because reaching `MAX_USES` forces LOCK.
- The key register persists across sequences, so repeated `start` pulses resend the same key.

## Timing
- `start` sampled at edge N gives `key_valid` = 1 after edge N.
- With `ready` held high, beats are transferred at edges N+1 through N+KEY_W.
- `done` is high for the one cycle following edge N+KEY_W.
- `busy` tracks `key_valid` exactly.
- The consumer samples `key_bit` on the falling edge of `clk`. Because `key_bit` launches on the rising edge, it has half a cycle of setup and hold.
- `rst` asserted mid-sequence clears all outputs immediately. No `done` is produced and `loaded` clears.

## Configuration
- `KEY_SEQ_TX_PARITY_EN` defined:
  - After the KEY_W data beats, one extra beat is sent carrying the even-parity bit (XOR of all key bits).
  - The sequence length is KEY_W+1 beats, and `done` and `uses` update only after the parity beat is accepted.
- Not defined: the sequence is exactly KEY_W beats with no parity beat.

## Test plan
- **Reset and idle:** reset, then `start` with `loaded` = 0 -> `key_valid` stays 0, `uses` = 0, all outputs 0.
- **Full sequence:**
  - Stimulus: load 8'hA5, `start`, `ready` held 1.
  - Required response: `key_bit` sequence 1,0,1,0,0,1,0,1; `done` pulses one cycle after the 8th beat; `uses` = 1.
  - With `KEY_SEQ_TX_PARITY_EN` defined, a 9th beat = 0 is sent before `done`.
- **Backpressure:**
  - Stimulus: key 8'h01; `ready` low for 3 cycles after beat 0 is presented.
  - Required response: `key_bit` stays 1 throughout the stall; total transfer takes 11 cycles.
- **Abort and mid-sequence reset:**
  - Stimulus: `abort` after 4 beats.
  - Required response: IDLE, no `done`, `uses` unchanged; a restart sends from bit 0.
  - Stimulus: `rst` asserted at beat 5.
  - Required response: all outputs 0 immediately and `loaded` = 0.
- **Lockout:**
  - Stimulus: with `MAX_USES` = 4, run 4 complete sequences.
  - Required response: `lockout` = 1 and `uses` = 4; a further `load` or `start` gives no `key_valid`; only `rst` clears it.
- **Simultaneous load and start:**
  - Stimulus: in IDLE with key 8'h0F loaded, `load` = 1 with `key_in` = 8'hF0 and `start` = 1 in the same cycle.
  - Required response: key becomes 8'hF0 with no sequence; the next `start` sends 0,0,0,0,1,1,1,1.

Source files
------------

// File: rtl/key_seq_tx.sv
// key_seq_tx: shifts a loaded unlock key out LSB-first, one bit per valid/ready beat, and counts sequences.
// Optional KEY_SEQ_TX_PARITY_EN appends an even-parity beat. Lockout after MAX_USES sequences persists until rst.
module key_seq_tx #(
  parameter int KEY_W    = 8,
  parameter int MAX_USES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [KEY_W-1:0]              key_in,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          ready,
  output logic                          key_bit,
  output logic                          key_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          lockout,
  output logic [$clog2(MAX_USES+1)-1:0] uses
);

  localparam int UW = $clog2(MAX_USES + 1);
`ifdef KEY_SEQ_TX_PARITY_EN
  localparam int LEN = KEY_W + 1;
`else
  localparam int LEN = KEY_W;
`endif
  localparam int IW = $clog2(LEN + 1);
  localparam logic [IW-1:0] LAST     = IW'(LEN - 1);
  localparam logic [UW-1:0] USES_MAX = UW'(MAX_USES);

  typedef enum logic [1:0] {IDLE, SEND, LOCK} state_t;

  state_t            state, state_nxt;
  logic [KEY_W-1:0]  key_q, key_nxt;
  logic              loaded, loaded_nxt;
  logic [IW-1:0]     idx, idx_nxt, idx_inc;
  logic [UW-1:0]     uses_nxt, uses_inc;
  logic              bit_nxt, valid_nxt, done_nxt;

  // Beat i carries key[i]; the beat after the last key bit is the parity beat when enabled.
  function automatic logic beat_bit(input logic [KEY_W-1:0] k, input logic [IW-1:0] i);
    logic [KEY_W-1:0] sh;
    sh = k >> i;
`ifdef KEY_SEQ_TX_PARITY_EN
    if (i == IW'(KEY_W)) return ^k;
`endif
    return sh[0];
  endfunction

  assign idx_inc  = idx + IW'(1);
  assign uses_inc = uses + UW'(1);

  always_comb begin
    state_nxt  = state;
    key_nxt    = key_q;
    loaded_nxt = loaded;
    idx_nxt    = idx;
    bit_nxt    = key_bit;
    valid_nxt  = key_valid;
    done_nxt   = 1'b0;
    uses_nxt   = uses;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        bit_nxt   = 1'b0;
        // A load in the same cycle as start wins; the start is dropped.
        if (load) begin
          key_nxt    = key_in;
          loaded_nxt = 1'b1;
        end else if (start && loaded) begin
          state_nxt = SEND;
          idx_nxt   = '0;
          valid_nxt = 1'b1;
          bit_nxt   = key_q[0];
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          valid_nxt = 1'b0;
          bit_nxt   = 1'b0;
        end else if (ready) begin
          if (idx == LAST) begin
            idx_nxt   = '0;
            valid_nxt = 1'b0;
            bit_nxt   = 1'b0;
            done_nxt  = 1'b1;
            uses_nxt  = uses_inc;
            state_nxt = (uses_inc == USES_MAX) ? LOCK : IDLE;
          end else begin
            idx_nxt = idx_inc;
            bit_nxt = beat_bit(key_q, idx_inc);
          end
        end
      end
      default: begin
        valid_nxt = 1'b0;
        bit_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_q     <= '0;
      loaded    <= 1'b0;
      idx       <= '0;
      key_bit   <= 1'b0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lockout   <= 1'b0;
      uses      <= '0;
    end else begin
      state     <= state_nxt;
      key_q     <= key_nxt;
      loaded    <= loaded_nxt;
      idx       <= idx_nxt;
      key_bit   <= bit_nxt;
      key_valid <= valid_nxt;
      busy      <= valid_nxt;
      done      <= done_nxt;
      lockout   <= (state_nxt == LOCK);
      uses      <= uses_nxt;
    end
  end

endmodule

// File: tb/tb_key_seq_tx.sv
// Directed bench for key_seq_tx: vector table for a full sequence, hand sequences for the multi-cycle corners.
module tb_key_seq_tx;

  localparam int KEY_W    = 8;
  localparam int MAX_USES = 4;
`ifdef KEY_SEQ_TX_PARITY_EN
  localparam int LEN = KEY_W + 1;
`else
  localparam int LEN = KEY_W;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [KEY_W-1:0] key_in = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             ready = 1'b0;
  logic             key_bit, key_valid, busy, done, lockout;
  logic [2:0]       uses;

  int checks = 0;
  int failures = 0;

  key_seq_tx #(.KEY_W(KEY_W), .MAX_USES(MAX_USES)) dut (
    .clk(clk), .rst(rst), .load(load), .key_in(key_in), .start(start),
    .abort(abort), .ready(ready), .key_bit(key_bit), .key_valid(key_valid),
    .busy(busy), .done(done), .lockout(lockout), .uses(uses)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] kin;
    logic       st;
    logic       ab;
    logic       rdy;
    logic       e_bit;
    logic       e_vld;
    logic       e_done;
    logic       e_lock;
    logic [2:0] e_uses;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ld, input logic [7:0] kin, input logic st,
                              input logic ab, input logic rdy, input logic e_bit,
                              input logic e_vld, input logic e_done, input logic e_lock,
                              input logic [2:0] e_uses);
    vec_t v;
    v.ld = ld; v.kin = kin; v.st = st; v.ab = ab; v.rdy = rdy;
    v.e_bit = e_bit; v.e_vld = e_vld; v.e_done = e_done; v.e_lock = e_lock; v.e_uses = e_uses;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_idle(input string nm, input logic [2:0] exp_uses, input logic exp_lock);
    chk({nm, ".key_valid"}, key_valid, 0);
    chk({nm, ".key_bit"}, key_bit, 0);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".lockout"}, lockout, exp_lock);
    chk({nm, ".uses"}, uses, exp_uses);
  endtask

  // Pulse start, hold ready high and collect beats until done or the cycle budget runs out.
  task automatic run_seq(output logic [63:0] bits, output int nb, output int cyc, output bit got_done);
    bits = '0; nb = 0; cyc = 0; got_done = 0;
    start = 1; ready = 1;
    tick();
    start = 0;
    while (cyc < 40 && !got_done) begin
      if (key_valid) begin
        bits[nb] = key_bit;
        nb++;
      end
      tick();
      cyc++;
      if (done) got_done = 1;
    end
    ready = 0;
  endtask

  logic [63:0] bits;
  int          nb, cyc;
  bit          got_done;

  initial begin
    // Main table: stray start/abort while unloaded, then a full 8'hA5 sequence.
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 0));
`ifdef KEY_SEQ_TX_PARITY_EN
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0));
`endif
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));

    // Reset state, while asserted and after release.
    tick(); tick();
    chk_idle("reset_held", 0, 0);
    rst = 0;
    tick();
    chk_idle("reset_released", 0, 0);

    foreach (tbl[i]) begin
      load = tbl[i].ld; key_in = tbl[i].kin; start = tbl[i].st;
      abort = tbl[i].ab; ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d.key_bit", i), key_bit, tbl[i].e_bit);
      chk($sformatf("vec%0d.key_valid", i), key_valid, tbl[i].e_vld);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].e_vld);
      chk($sformatf("vec%0d.done", i), done, tbl[i].e_done);
      chk($sformatf("vec%0d.lockout", i), lockout, tbl[i].e_lock);
      chk($sformatf("vec%0d.uses", i), uses, tbl[i].e_uses);
    end
    load = 0; start = 0; abort = 0; ready = 0;

    // Backpressure: key 8'h01, ready low for 3 cycles after beat 0 appears.
    load = 1; key_in = 8'h01; tick(); load = 0;
    start = 1; ready = 0; tick(); start = 0;
    cyc = 0;
    while (cyc < 30) begin
      ready = (cyc >= 3);
      if (cyc <= 3) begin
        chk($sformatf("stall%0d.key_bit", cyc), key_bit, 1);
        chk($sformatf("stall%0d.key_valid", cyc), key_valid, 1);
      end
      tick();
      cyc++;
      if (done) break;
    end
    ready = 0;
    chk("backpressure.cycles", cyc, LEN + 3);
    chk("backpressure.done", done, 1);
    chk("backpressure.uses", uses, 2);

    // Abort after 4 beats, with ready also high on the abort edge.
    load = 1; key_in = 8'hA5; tick(); load = 0;
    start = 1; ready = 1; tick(); start = 0;
    repeat (4) tick();
    chk("abort.pre_key_bit", key_bit, 0);
    chk("abort.pre_key_valid", key_valid, 1);
    abort = 1; tick(); abort = 0; ready = 0;
    chk_idle("abort.after", 2, 0);
    tick();
    chk("abort.no_late_done", done, 0);
    run_seq(bits, nb, cyc, got_done);
    chk("restart.done", got_done, 1);
    chk("restart.beats", nb, LEN);
    chk("restart.bits", bits[7:0], 8'hA5);
    chk("restart.uses", uses, 3);

    // Simultaneous load and start: load wins, no sequence.
    load = 1; key_in = 8'h0F; tick();
    key_in = 8'hF0; start = 1; tick();
    load = 0; start = 0;
    chk("ldst.key_valid", key_valid, 0);
    tick();
    chk("ldst.key_valid_later", key_valid, 0);
    run_seq(bits, nb, cyc, got_done);
    chk("ldst.done", got_done, 1);
    chk("ldst.cycles", cyc, LEN);
    chk("ldst.bits", bits[7:0], 8'hF0);
`ifdef KEY_SEQ_TX_PARITY_EN
    chk("ldst.parity", bits[8], 0);
`endif

    // Fourth completed sequence locks the block.
    chk("lock.lockout", lockout, 1);
    chk("lock.uses", uses, 4);
    load = 1; key_in = 8'hAA; start = 1; ready = 1; tick();
    load = 0; tick(); tick();
    start = 0; ready = 0;
    chk_idle("lock.hold", 4, 1);

    // Mid-sequence reset clears outputs without waiting for an edge.
    rst = 1; tick(); rst = 0; tick();
    chk_idle("unlock", 0, 0);
    load = 1; key_in = 8'h3C; tick(); load = 0;
    start = 1; ready = 1; tick(); start = 0;
    repeat (5) tick();
    chk("midrst.pre_key_valid", key_valid, 1);
    #1 rst = 1;
    #1 chk_idle("midrst.immediate", 0, 0);
    #1 rst = 0;
    ready = 0;
    tick();
    start = 1; tick(); start = 0;
    chk("midrst.unloaded_start", key_valid, 0);
    tick();
    chk_idle("midrst.after", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
